muldiv_unit: RTL

- Iterative multiply/divide unit for the RV32M extension, parametrised in data width.
- Sits beside the single-cycle ALU in the execute stage and takes the same operand-select style: register or immediate second operand.
- Uses a valid/ready handshake on both input and output, so the pipeline stalls while an operation is in flight.
- One operation in flight at a time; radix-2, one bit per cycle.

---
 rtl/muldiv_unit.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative radix-2 multiply/divide unit for the RV32M extension. One bit of
// the product or quotient is produced per clock; one operation is in flight at
// a time. Operands are reduced to magnitudes on accept, the core loop runs
// unsigned, and the FIX state restores signs and picks the requested half.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort; forces IDLE on the next edge, no result
//   in_valid   request valid            in_ready   high only in IDLE
//   op         RV32M funct3 (MUL..REMU)
//   alusrc     1 = second operand is immop, 0 = regop2
//   aluop1     first operand (rs1)
//   regop2     register second operand  immop      immediate second operand
//   out_valid  result valid (DONE)      out_ready  consumer accepts result
//   result     result, stable while out_valid is held
//   busy       state is not IDLE
//
// Optional build macro MULDIV_EARLY_OUT_EN: divide by zero, signed overflow
// and any zero operand jump straight from IDLE to DONE. Results are the same
// with or without the macro; only the latency changes.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic               alusrc,
    input  logic [D_WIDTH-1:0] aluop1,
    input  logic [D_WIDTH-1:0] regop2,
    input  logic [D_WIDTH-1:0] immop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] result,
    output logic               busy
);

    localparam int CNT_W = $clog2(D_WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(D_WIDTH - 1);
    localparam logic [D_WIDTH-1:0] MIN_VAL  = {1'b1, {(D_WIDTH-1){1'b0}}};

    // Two's-complement magnitude when the operand is treated as negative.
    function automatic logic [D_WIDTH-1:0] magnitude(input logic [D_WIDTH-1:0] x,
                                                     input logic is_neg);
        return is_neg ? -x : x;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [D_WIDTH-1:0] hi_q, hi_d;        // product high half / partial remainder
    logic [D_WIDTH-1:0] lo_q, lo_d;        // multiplier bits / dividend-quotient bits
    logic [D_WIDTH-1:0] mcand_q, mcand_d;  // multiplicand magnitude / divisor magnitude
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [D_WIDTH-1:0] result_q, result_d;

    // Operand decode on the request side.
    logic [D_WIDTH-1:0] op2;
    logic               a_signed, b_signed;
    logic               in_a_neg, in_b_neg;
    logic [D_WIDTH-1:0] a_mag, b_mag;

    assign op2      = alusrc ? immop : regop2;
    // Signed rs1: MUL, MULH, MULHSU, DIV, REM. Signed rs2: MUL, MULH, DIV, REM.
    assign a_signed = (op[2] == 1'b0) ? (op[1:0] != 2'b11) : (op[0] == 1'b0);
    assign b_signed = (op[2] == 1'b0) ? (op[1] == 1'b0)    : (op[0] == 1'b0);
    assign in_a_neg = a_signed & aluop1[D_WIDTH-1];
    assign in_b_neg = b_signed & op2[D_WIDTH-1];
    assign a_mag    = magnitude(aluop1, in_a_neg);
    assign b_mag    = magnitude(op2, in_b_neg);

    // Shift-add step: add the multiplicand when the current multiplier bit is
    // set, then shift {carry, hi, lo} right so the product fills in from the top.
    logic [D_WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {D_WIDTH{1'b0}})};

    // Restoring step: shift the next dividend bit into the remainder and keep
    // the subtraction only if it did not go negative (bit D_WIDTH clear).
    logic [D_WIDTH:0] div_shift, div_trial;
    assign div_shift = {hi_q, lo_q[D_WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mcand_q};

    // Sign restoration and half/quotient/remainder selection for FIX.
    logic [2*D_WIDTH-1:0] prod_fixed;
    logic [D_WIDTH-1:0]   quo_fixed, rem_fixed, fix_result;
    logic                 div_by_zero;

    always_comb begin
        prod_fixed  = (a_neg_q ^ b_neg_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
        div_by_zero = (mcand_q == {D_WIDTH{1'b0}});
        // A zero divisor leaves |rs1| in hi, so the sign fix below restores rs1
        // exactly; only the quotient needs forcing to all ones.
        quo_fixed   = div_by_zero ? {D_WIDTH{1'b1}}
                                  : magnitude(lo_q, a_neg_q ^ b_neg_q);
        rem_fixed   = magnitude(hi_q, a_neg_q);
        if (op_q[2] == 1'b0) begin
            fix_result = (op_q[1:0] == 2'b00) ? prod_fixed[D_WIDTH-1:0]
                                              : prod_fixed[2*D_WIDTH-1:D_WIDTH];
        end else begin
            fix_result = op_q[1] ? rem_fixed : quo_fixed;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Cases whose answer is known from the operands alone.
    logic               early_hit;
    logic [D_WIDTH-1:0] early_val;

    always_comb begin
        early_hit = 1'b0;
        early_val = {D_WIDTH{1'b0}};
        if (op[2]) begin
            if (op2 == {D_WIDTH{1'b0}}) begin
                early_hit = 1'b1;
                early_val = op[1] ? aluop1 : {D_WIDTH{1'b1}};
            end else if (!op[0] && aluop1 == MIN_VAL && op2 == {D_WIDTH{1'b1}}) begin
                early_hit = 1'b1;
                early_val = op[1] ? {D_WIDTH{1'b0}} : MIN_VAL;
            end else if (aluop1 == {D_WIDTH{1'b0}}) begin
                early_hit = 1'b1;
            end
        end else if (aluop1 == {D_WIDTH{1'b0}} || op2 == {D_WIDTH{1'b0}}) begin
            early_hit = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        result_d = result_q;

        if (flush) begin
            // Abort wins over everything, including an accept or a FIX update.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d    = op;
                        cnt_d   = {CNT_W{1'b0}};
                        hi_d    = {D_WIDTH{1'b0}};
                        a_neg_d = in_a_neg;
                        b_neg_d = in_b_neg;
                        if (op[2]) begin
                            lo_d    = a_mag;
                            mcand_d = b_mag;
                        end else begin
                            lo_d    = b_mag;
                            mcand_d = a_mag;
                        end
                        state_d = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit) begin
                            result_d = early_val;
                            state_d  = S_DONE;
                        end
`endif
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (op_q[2]) begin
                        if (!div_trial[D_WIDTH]) begin
                            hi_d = div_trial[D_WIDTH-1:0];
                            lo_d = {lo_q[D_WIDTH-2:0], 1'b1};
                        end else begin
                            hi_d = div_shift[D_WIDTH-1:0];
                            lo_d = {lo_q[D_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = mul_sum[D_WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[D_WIDTH-1:1]};
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = fix_result;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 3'b000;
            cnt_q    <= {CNT_W{1'b0}};
            hi_q     <= {D_WIDTH{1'b0}};
            lo_q     <= {D_WIDTH{1'b0}};
            mcand_q  <= {D_WIDTH{1'b0}};
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            result_q <= {D_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

endmodule
